// File: rtl/seq_ripple_adder_if.sv
// Handshake and operand/result bundle for seq_ripple_adder.
// The master drives the request; the slave (the adder) returns status and result.
interface seq_ripple_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/seq_ripple_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, carry kept in a flop between chunks.
// Operands shift right one chunk per cycle; partial sums shift in from the top of a result register.
module seq_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst,
    seq_ripple_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK:0]         chunk_sum;
    logic [WIDTH+CHUNK-1:0] res_shift;
    logic [WIDTH-1:0]       res_new;
    logic                   last_chunk;

    // Only the low chunk of each operand enters the adder; carry comes solely from carry_q.
    always_comb begin
        chunk_sum  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
        res_shift  = {chunk_sum[CHUNK-1:0], res_q};
        res_new    = res_shift[WIDTH+CHUNK-1:CHUNK];
        last_chunk = (cnt_q == CW'(NCHUNK - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    state_d = S_RUN;
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? ~bus.cin : bus.cin;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.sub ^ bus.b[WIDTH-1];
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                res_d   = res_new;
                carry_d = chunk_sum[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (last_chunk) begin
                    state_d = S_DONE;
                    s_d     = res_new;
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = (a_msb_q == b_msb_q) && (res_new[WIDTH-1] != a_msb_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_ripple_adder.sv
// Random and directed bench for seq_ripple_adder in three configurations (16/4, 4/1, 4/4),
// checked every cycle against an arithmetic model with a fixed-latency completion schedule.
module tb_seq_ripple_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_ripple_adder_if #(.WIDTH(16)) if0 ();
    seq_ripple_adder_if #(.WIDTH(4))  if1 ();
    seq_ripple_adder_if #(.WIDTH(4))  if2 ();

    seq_ripple_adder #(.WIDTH(16), .CHUNK(4)) u0 (.clk(clk), .rst(rst), .bus(if0));
    seq_ripple_adder #(.WIDTH(4),  .CHUNK(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    seq_ripple_adder #(.WIDTH(4),  .CHUNK(4)) u2 (.clk(clk), .rst(rst), .bus(if2));

    int n_checks = 0;
    int n_fail   = 0;
    int n_print  = 0;
    bit chk_en   = 1'b0;

    // Model state per instance
    bit m_busy[3], m_done[3], m_cout[3], m_ovf[3];
    int m_s[3], m_rem[3];
    int p_s[3];
    bit p_cout[3], p_ovf[3];

    function automatic int w_of(int i);
        return (i == 0) ? 16 : 4;
    endfunction

    function automatic int n_of(int i);
        return (i == 0) ? 4 : ((i == 1) ? 4 : 1);
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Plain integer arithmetic reference: true sum/difference, unsigned carry, signed range.
    task automatic ref_op(input int w, input bit sb, input int a, input int b, input bit ci,
                          output int s, output bit co, output bit ov);
        int mask, sa, sbv, t, st;
        mask = (1 << w) - 1;
        sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sbv  = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        if (!sb) begin
            t  = a + b + int'(ci);
            co = (t > mask);
            st = sa + sbv + int'(ci);
        end else begin
            t  = a - b - int'(ci);
            co = (a >= b + int'(ci));
            st = sa - sbv - int'(ci);
        end
        s  = t & mask;
        ov = (st > (1 << (w - 1)) - 1) || (st < -(1 << (w - 1)));
    endtask

    task automatic model_step(int i, bit st, bit sb, int a, int b, bit ci);
        if (rst) begin
            m_busy[i] = 0; m_done[i] = 0; m_s[i] = 0; m_cout[i] = 0; m_ovf[i] = 0; m_rem[i] = 0;
        end else if (m_busy[i]) begin
            m_done[i] = 0;
            m_rem[i]--;
            if (m_rem[i] == 0) begin
                m_busy[i] = 0; m_done[i] = 1;
                m_s[i] = p_s[i]; m_cout[i] = p_cout[i]; m_ovf[i] = p_ovf[i];
            end
        end else begin
            m_done[i] = 0;
            if (st) begin
                ref_op(w_of(i), sb, a, b, ci, p_s[i], p_cout[i], p_ovf[i]);
                m_rem[i]  = n_of(i);
                m_busy[i] = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, if0.start, if0.sub, int'(if0.a), int'(if0.b), if0.cin);
        model_step(1, if1.start, if1.sub, int'(if1.a), int'(if1.b), if1.cin);
        model_step(2, if2.start, if2.sub, int'(if2.a), int'(if2.b), if2.cin);
    end

    // Cycle-by-cycle comparison of every instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic [19:0] got, exp;
                case (i)
                    0:       got = {if0.busy, if0.done, if0.cout, if0.ovf, if0.s};
                    1:       got = {if1.busy, if1.done, if1.cout, if1.ovf, 12'h0, if1.s};
                    default: got = {if2.busy, if2.done, if2.cout, if2.ovf, 12'h0, if2.s};
                endcase
                exp = {m_busy[i], m_done[i], m_cout[i], m_ovf[i], 16'(m_s[i])};
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    if (n_print < 30) begin
                        n_print++;
                        $display("FAIL cycle_dut%0d got{busy,done,cout,ovf,s}=%0h expected=%0h at %0t",
                                 i, got, exp, $time);
                    end
                end
            end
        end
    end

    task automatic drive(int i, bit st, bit sb, int a, int b, bit ci);
        case (i)
            0: begin if0.start = st; if0.sub = sb; if0.a = 16'(a); if0.b = 16'(b); if0.cin = ci; end
            1: begin if1.start = st; if1.sub = sb; if1.a = 4'(a);  if1.b = 4'(b);  if1.cin = ci; end
            default: begin if2.start = st; if2.sub = sb; if2.a = 4'(a); if2.b = 4'(b); if2.cin = ci; end
        endcase
    endtask

    task automatic scramble(int i, bit st);
        drive(i, st, 1'($urandom), int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
              1'($urandom));
    endtask

    task automatic wait_idle(int i);
        int n = 0;
        while (m_busy[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", 32'(n < 100), 32'd1);
    endtask

    // Directed op on the 16/4 instance with literal expectations; a stray start
    // pulse and operand scrambling are injected while busy.
    task automatic do_op(string nm, bit sb, int a, int b, bit ci, int es, bit ec, bit eo);
        int lat = 0, busy_cnt = 0;
        bit seen = 0;
        wait_idle(0);
        drive(0, 1'b1, sb, a, b, ci);
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (if0.done) seen = 1;
            else begin
                if (if0.busy) busy_cnt++;
                scramble(0, lat == 2);
            end
        end
        chk({nm, "_done_latency"}, 32'(lat - 1), 32'd4);
        chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
        chk({nm, "_s"}, 32'(if0.s), 32'(es));
        chk({nm, "_cout"}, 32'(if0.cout), 32'(ec));
        chk({nm, "_ovf"}, 32'(if0.ovf), 32'(eo));
        drive(0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic exhaustive(int i);
        for (int v = 0; v < 1024; v++) begin
            wait_idle(i);
            drive(i, 1'b1, v[9], v & 15, (v >> 4) & 15, v[8]);
            @(negedge clk);
            scramble(i, 1'b0);
        end
        wait_idle(i);
        @(negedge clk);
        drive(i, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        int last_done, dcnt;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 0, 0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_busy", 32'(if0.busy), 32'd0);
        chk("reset_done", 32'(if0.done), 32'd0);
        chk("reset_s", 32'(if0.s), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("add_basic",   1'b0, 'h1234, 'h4321, 1'b0, 'h5555, 1'b0, 1'b0);
        do_op("add_ripple",  1'b0, 'hFFFF, 'h0001, 1'b0, 'h0000, 1'b1, 1'b0);
        do_op("add_ovf",     1'b0, 'h7FFF, 'h0001, 1'b0, 'h8000, 1'b0, 1'b1);
        do_op("add_cin",     1'b0, 'h0000, 'h0000, 1'b1, 'h0001, 1'b0, 1'b0);
        do_op("sub_neg",     1'b1, 'h0005, 'h0007, 1'b0, 'hFFFE, 1'b0, 1'b0);
        do_op("sub_ovf",     1'b1, 'h8000, 'h0001, 1'b0, 'h7FFF, 1'b1, 1'b1);
        do_op("sub_borrow",  1'b1, 'h0010, 'h0001, 1'b1, 'h000E, 1'b1, 1'b0);

        // start held high: completions every NCHUNK+1 cycles
        wait_idle(0);
        last_done = -1;
        for (int c = 0; c < 26; c++) begin
            scramble(0, 1'b1);
            @(negedge clk);
            if (if0.done) begin
                if (last_done >= 0) chk("b2b_spacing", 32'(c - last_done), 32'd5);
                last_done = c;
            end
        end
        drive(0, 1'b0, 1'b0, 0, 0, 1'b0);

        // reset two cycles after start abandons the operation
        wait_idle(0);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 'h1111, 'h2222, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", 32'(if0.busy), 32'd0);
        chk("rst_mid_s", 32'(if0.s), 32'd0);
        chk("rst_mid_cout", 32'(if0.cout), 32'd0);
        dcnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (if0.done) dcnt++;
        end
        chk("rst_mid_no_done", 32'(dcnt), 32'd0);
        do_op("after_rst",   1'b0, 'h1234, 'h4321, 1'b0, 'h5555, 1'b0, 1'b0);

        // random traffic on all instances, occasional reset
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) scramble(i, ($urandom % 3) == 0);
            rst = (($urandom % 97) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clk);

        fork
            exhaustive(1);
            exhaustive(2);
        join
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_ripple_adder.md
Name: seq_ripple_adder

Overview:
- Multi-cycle, parametrised ripple-carry adder/subtractor.
- Generalises the fixed 4-bit combinational adder: operands of WIDTH bits, added CHUNK bits per clock, carry held in a register between cycles.
- Adds a subtract mode, a signed-overflow flag and a start/busy/done handshake.
- Used where a full-width single-cycle carry chain would break timing, or where area must stay small.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when not busy.
- sub  input  1  0 = add, 1 = subtract; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in (add) or borrow-in (sub); sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when s, cout and ovf are updated.
- s  output  WIDTH  result, registered.
- cout  output  1  carry-out; in sub mode 1 = no borrow.
- ovf  output  1  two's-complement signed overflow of the result.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; busy=0, done=0, s=0, cout=0, ovf=0; internal operand, carry and chunk counter cleared.
- Reset has priority over everything, including an operation in progress, which is abandoned with no done pulse.
- FSM states:
  - IDLE: start=1 -> RUN. Latch A=a, B=(sub ? ~b : b), carry=(sub ? ~cin : cin), counter=0.
  - RUN: each cycle adds chunk [counter*CHUNK +: CHUNK] of A and B plus carry.
    - Stores the chunk sum into an internal result shift register and updates carry.
    - Counter increments; after chunk NCHUNK-1 -> DONE.
  - DONE: one cycle, then -> IDLE. If start=1 in DONE, go directly to RUN with new operands (back-to-back operation).
- Arithmetic:
  - add: {cout,s} = a + b + cin.
  - sub: s = a - b - cin, computed as a + ~b + ~cin; cout = final raw carry.
  - ovf = (A[WIDTH-1] == B[WIDTH-1]) && (s[WIDTH-1] != A[WIDTH-1]), using the latched, possibly inverted, B.
- Timing: start sampled at edge k.
  - busy=1 from edge k+1 through edge k+NCHUNK.
  - s, cout and ovf update at edge k+NCHUNK; done=1 and busy=0 for the following cycle.
  - done-to-done spacing for back-to-back starts is NCHUNK+1 cycles.
- s, cout and ovf stay constant except at the completion edge; no intermediate values are visible.
- start while busy=1 is ignored; a, b, sub and cin may change freely while busy without affecting the result.
- CHUNK=WIDTH is legal: one RUN cycle, latency 1 plus the done cycle.
- Carry between chunks is carried only through the carry register, never combinationally across chunk boundaries.

Test Plan:
- WIDTH=16, CHUNK=4, add, a=0x1234, b=0x4321, cin=0 -> s=0x5555, cout=0, ovf=0; done exactly 4 edges after start, busy high for 4 cycles.
- Add carry ripple and overflow:
  - a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0.
  - a=0x7FFF, b=0x0001 -> s=0x8000, cout=0, ovf=1.
  - a=0x0000, b=0x0000, cin=1 -> s=0x0001.
- Subtract:
  - a=0x0005, b=0x0007, cin=0, sub=1 -> s=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, cout=1, ovf=1.
  - a=0x0010, b=0x0001, cin=1, sub=1 -> s=0x000E, cout=1.
- Handshake:
  - start held high throughout -> results every 5 cycles.
  - Second start pulse during busy -> ignored.
  - Operands changed mid-RUN -> result unaffected.
- Reset mid-op: rst=1 two cycles after start -> next cycle busy=0, s=0, no done pulse; a fresh start afterwards completes normally.
- Exhaustive: WIDTH=4, CHUNK=1 and WIDTH=4, CHUNK=4, all a, b, cin and sub combinations (1024 each) -> {cout,s} and ovf match the reference model; latency is NCHUNK each time.
